// File: rtl/bram_fifo_pkg.sv
// rtl/bram_fifo_pkg.sv - shared constants for the block-RAM FWFT FIFO
package bram_fifo_pkg;

  localparam int SKID_DEPTH       = 2;
  localparam int LEVEL_EXTRA_BITS = 2;

  // level counts RAM words plus the in-flight read plus the skid entries
  function automatic int level_width(input int addr_width);
    return addr_width + LEVEL_EXTRA_BITS;
  endfunction

endpackage

// File: rtl/bram_fifo_mem.sv
// rtl/bram_fifo_mem.sv - simple dual-port block RAM, one write port, one registered read port
module bram_fifo_mem
  import bram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 4000,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_o <= mem_q[rd_addr_i];
    end
  end

endmodule

// File: rtl/bram_fifo.sv
// rtl/bram_fifo.sv - first-word-fall-through FIFO on block RAM with a 2-entry output skid buffer
// Optional high-watermark register enabled by BRAM_FIFO_WATERMARK_EN.
module bram_fifo
  import bram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 4000,
  parameter int ADDR_WIDTH   = 3,
  parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_WIDTH-1:0]               in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic [level_width(ADDR_WIDTH)-1:0]  level,
  output logic                                afull,
  output logic [level_width(ADDR_WIDTH)-1:0]  max_level
);

  localparam int                LW       = level_width(ADDR_WIDTH);
  localparam int                RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] MEM_FULL = (ADDR_WIDTH+1)'(RAM_DEPTH);

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   mem_cnt_q, mem_cnt_d;
  logic [1:0]            skid_cnt_q, skid_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] skid0_q, skid0_d;
  logic [DATA_WIDTH-1:0] skid1_q, skid1_d;
  logic [DATA_WIDTH-1:0] rd_data;

  logic       push, pop, issue, land;
  logic [2:0] skid_occ;

  assign in_ready  = rst_n && (mem_cnt_q != MEM_FULL) && !flush;
  assign out_valid = (skid_cnt_q != 2'd0);
  assign out_data  = skid0_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;
  assign land = inflight_q;

  // Only issue a read if its result is guaranteed a free skid slot on landing
  assign skid_occ = {1'b0, skid_cnt_q} + {2'b00, inflight_q};
  assign issue    = (mem_cnt_q != '0) && !flush &&
                    (skid_occ < (3'(SKID_DEPTH) + {2'b00, pop}));

  bram_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (push),
    .wr_addr_i (wptr_q),
    .wr_data_i (in_data),
    .rd_en_i   (issue),
    .rd_addr_i (rptr_q),
    .rd_data_o (rd_data)
  );

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    mem_cnt_d  = mem_cnt_q;
    skid_cnt_d = skid_cnt_q;
    inflight_d = inflight_q;
    skid0_d    = skid0_q;
    skid1_d    = skid1_q;
    if (flush) begin
      wptr_d     = '0;
      rptr_d     = '0;
      mem_cnt_d  = '0;
      skid_cnt_d = '0;
      inflight_d = 1'b0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (issue) rptr_d = rptr_q + 1'b1;
      mem_cnt_d  = mem_cnt_q + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, issue};
      inflight_d = issue;
      skid_cnt_d = skid_cnt_q + {1'b0, land} - {1'b0, pop};
      // skid0 is always the head; skid1 only fills behind a stalled head
      case (skid_cnt_q)
        2'd0: begin
          if (land) skid0_d = rd_data;
        end
        2'd1: begin
          if (pop) begin
            if (land) skid0_d = rd_data;
          end else if (land) begin
            skid1_d = rd_data;
          end
        end
        default: begin
          if (pop) begin
            skid0_d = skid1_q;
            if (land) skid1_d = rd_data;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      mem_cnt_q  <= '0;
      skid_cnt_q <= '0;
      inflight_q <= 1'b0;
      skid0_q    <= '0;
      skid1_q    <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      mem_cnt_q  <= mem_cnt_d;
      skid_cnt_q <= skid_cnt_d;
      inflight_q <= inflight_d;
      skid0_q    <= skid0_d;
      skid1_q    <= skid1_d;
    end
  end

  assign level = LW'(mem_cnt_q) + LW'(inflight_q) + LW'(skid_cnt_q);
  assign afull = (level >= LW'(AFULL_THRESH));

`ifdef BRAM_FIFO_WATERMARK_EN
  logic [LW-1:0] max_level_q, max_level_d;

  // Survives flush on purpose: it tracks the peak since the last reset
  always_comb begin
    max_level_d = max_level_q;
    if (level > max_level_q) max_level_d = level;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) max_level_q <= '0;
    else        max_level_q <= max_level_d;
  end

  assign max_level = max_level_q;
`else
  assign max_level = '0;
`endif

endmodule

// File: tb/tb_bram_fifo.sv
// tb/tb_bram_fifo.sv - self-checking bench for bram_fifo
module tb_bram_fifo;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int LW = AW + 2;
`ifdef BRAM_FIFO_WATERMARK_EN
  localparam int EXP_MAX = 6;
`else
  localparam int EXP_MAX = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [LW-1:0] level;
  logic          afull;
  logic [LW-1:0] max_level;

  int n_cmp = 0;
  int n_err = 0;

  bram_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .afull     (afull),
    .max_level (max_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          fl;
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          e_ir;
    logic          e_ov;
    logic [DW-1:0] e_od;
    logic [LW-1:0] e_lvl;
    logic          e_af;
  } vec_t;

  vec_t tv [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [DW-1:0] d, input logic ordy);
    flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_stream(input int n, input bit toggle, input int base);
    int sent = 0;
    int got = 0;
    int first = -1;
    int last = -1;
    bit stall_prev = 1'b0;
    logic [DW-1:0] held = '0;
    for (int cyc = 0; cyc < 800 && got < n; cyc++) begin
      flush = 1'b0;
      in_valid = (sent < n);
      in_data = DW'(base + sent);
      out_ready = toggle ? cyc[0] : 1'b1;
      @(negedge clk);
      if (stall_prev) chk("stall_hold", out_data, held);
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        chk("stream_order", out_data, DW'(base + got));
        if (got == 0) first = cyc;
        last = cyc;
        got++;
      end
      stall_prev = out_valid && !out_ready;
      held = out_data;
      step();
    end
    chk("stream_count", got, n);
    if (!toggle) chk("stream_no_gaps", last - first, n - 1);
  endtask

  initial begin
    int sent;
    int got;
    bit found;

    tv[0]  = '{1'b0, 1'b1, 16'hA5, 1'b0, 1'b1, 1'b0, 16'h00, 5'd0, 1'b0};
    tv[1]  = '{1'b0, 1'b0, 16'h00, 1'b0, 1'b1, 1'b0, 16'h00, 5'd1, 1'b0};
    tv[2]  = '{1'b0, 1'b0, 16'h00, 1'b0, 1'b1, 1'b0, 16'h00, 5'd1, 1'b0};
    tv[3]  = '{1'b0, 1'b0, 16'h00, 1'b0, 1'b1, 1'b1, 16'hA5, 5'd1, 1'b0};
    tv[4]  = '{1'b0, 1'b1, 16'h11, 1'b1, 1'b1, 1'b1, 16'hA5, 5'd1, 1'b0};
    tv[5]  = '{1'b0, 1'b1, 16'h22, 1'b1, 1'b1, 1'b0, 16'h00, 5'd1, 1'b0};
    tv[6]  = '{1'b0, 1'b0, 16'h00, 1'b1, 1'b1, 1'b0, 16'h00, 5'd2, 1'b0};
    tv[7]  = '{1'b0, 1'b0, 16'h00, 1'b0, 1'b1, 1'b1, 16'h11, 5'd2, 1'b0};
    tv[8]  = '{1'b0, 1'b0, 16'h00, 1'b0, 1'b1, 1'b1, 16'h11, 5'd2, 1'b0};
    tv[9]  = '{1'b0, 1'b0, 16'h00, 1'b1, 1'b1, 1'b1, 16'h11, 5'd2, 1'b0};
    tv[10] = '{1'b0, 1'b0, 16'h00, 1'b1, 1'b1, 1'b1, 16'h22, 5'd1, 1'b0};
    tv[11] = '{1'b0, 1'b0, 16'h00, 1'b0, 1'b1, 1'b0, 16'h00, 5'd0, 1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_max_level", max_level, 0);
    step();
    rst_n = 1'b1;

    // single word then a short push/pop interleave
    for (int i = 0; i < 12; i++) begin
      drive(tv[i].fl, tv[i].iv, tv[i].d, tv[i].ordy);
      chk($sformatf("v%0d_in_ready", i), in_ready, tv[i].e_ir);
      chk($sformatf("v%0d_out_valid", i), out_valid, tv[i].e_ov);
      if (tv[i].e_ov) chk($sformatf("v%0d_out_data", i), out_data, tv[i].e_od);
      chk($sformatf("v%0d_level", i), level, tv[i].e_lvl);
      chk($sformatf("v%0d_afull", i), afull, tv[i].e_af);
      step();
    end

    // fill to total capacity with the consumer stalled
    sent = 0;
    for (int c = 0; c < 40 && sent < 10; c++) begin
      drive(1'b0, 1'b1, DW'(sent), 1'b0);
      chk("fill_level", level, sent);
      chk("fill_afull", afull, (sent >= 7));
      if (in_ready) sent++;
      step();
    end
    drive(1'b0, 1'b1, 16'h99, 1'b0);
    chk("full_in_ready", in_ready, 0);
    chk("full_level", level, 10);
    chk("full_afull", afull, 1);
    chk("full_head", out_data, 0);
    step();
    got = 0;
    for (int c = 0; c < 40 && got < 10; c++) begin
      drive(1'b0, 1'b0, '0, 1'b1);
      if (out_valid) begin
        chk("drain_order", out_data, got);
        got++;
      end
      step();
    end
    chk("drain_count", got, 10);
    drive(1'b0, 1'b0, '0, 1'b0);
    chk("drain_level", level, 0);
    step();

    run_stream(100, 1'b0, 16'h1000);
    run_stream(40, 1'b1, 16'h2000);

    // flush with a read in flight, simultaneous push and pop ignored
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, DW'(16'h100 + i), 1'b0);
      step();
    end
    drive(1'b0, 1'b1, 16'h105, 1'b1);
    chk("pf_head", out_data, 16'h100);
    step();
    drive(1'b1, 1'b1, 16'h55, 1'b1);
    chk("pf_level", level, 5);
    chk("pf_in_ready", in_ready, 0);
    step();
    drive(1'b0, 1'b0, '0, 1'b0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_level", level, 0);
    chk("flush_in_ready", in_ready, 1);
    step();
    drive(1'b0, 1'b1, 16'h77, 1'b0);
    step();
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      drive(1'b0, 1'b0, '0, 1'b0);
      if (out_valid) found = 1'b1;
      else step();
    end
    chk("post_flush_seen", found, 1);
    chk("post_flush_data", out_data, 16'h77);
    chk("post_flush_level", level, 1);
    step();
    drive(1'b0, 1'b0, '0, 1'b1);
    step();
    drive(1'b0, 1'b0, '0, 1'b0);
    chk("post_flush_empty", level, 0);
    step();

    // asynchronous reset while holding data
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, DW'(16'h300 + i), 1'b0);
      step();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_max_level", max_level, 0);
    chk("mid_rst_afull", afull, 0);
    step();
    rst_n = 1'b1;

    // watermark: peak of 6 then drain
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, DW'(16'h200 + i), 1'b0);
      step();
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    chk("wm_level", level, 6);
    chk("wm_afull", afull, 0);
    step();
    got = 0;
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, 1'b0, '0, 1'b1);
      if (out_valid) begin
        chk("wm_order", out_data, 16'h200 + got);
        got++;
      end
      step();
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    chk("wm_count", got, 6);
    chk("wm_drained", level, 0);
    chk("wm_max_level", max_level, EXP_MAX);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
